// File: rtl/cam_dvp_pkg.sv
// Shared types for the DVP test-pattern source: FSM states, pattern codes, colour-bar palette.
// Pure declarations; no timing or flow control of its own.
package cam_dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_t;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_FLAT  = 2'd2,
        PAT_CHECK = 2'd3
    } pat_sel_t;

    localparam logic [11:0] BAR_WHITE   = 12'hFFF;
    localparam logic [11:0] BAR_YELLOW  = 12'hFF0;
    localparam logic [11:0] BAR_CYAN    = 12'h0FF;
    localparam logic [11:0] BAR_GREEN   = 12'h0F0;
    localparam logic [11:0] BAR_MAGENTA = 12'hF0F;
    localparam logic [11:0] BAR_RED     = 12'hF00;
    localparam logic [11:0] BAR_BLUE    = 12'h00F;
    localparam logic [11:0] BAR_BLACK   = 12'h000;

    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/cam_dvp_pattern.sv
// Combinational RGB444 pixel generator from pixel position, bar index, pattern select and frame count.
// Zero latency; no flow control.
module cam_dvp_pattern
    import cam_dvp_pkg::*;
(
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [2:0]  bar,
    input  pat_sel_t    sel,
    input  logic [11:0] fcnt,
    output logic [11:0] pix
);

    // Upper coordinate bits do not feed any pattern.
    logic unused_bits;
    assign unused_bits = ^{x[9:8], y[9:5]};

    always_comb begin
        pix = 12'h000;
        case (sel)
            PAT_BARS:  pix = bar_colour(bar);
            PAT_RAMP:  pix = {x[3:0], x[7:4], y[3:0]};
            PAT_FLAT:  pix = fcnt;
            PAT_CHECK: pix = (x[4] ^ y[4]) ? 12'hFFF : 12'h000;
            default:   pix = 12'h000;
        endcase
    end

endmodule

// File: rtl/cam_dvp_source.sv
// OV7670-style DVP transmitter: frame FSM, line/pixel counters, RGB444 byte mux, registered outputs.
// Outputs lag the FSM by one cycle; free-running source with no backpressure.
module cam_dvp_source
    import cam_dvp_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        cam_vsynk,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
    localparam int HC_W      = $clog2(LINE_LEN);
    localparam int MAX_A     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int MAX_B     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int VC_W      = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
    localparam int BAR_W     = H_ACTIVE / 8;
    localparam int BP_W      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    // ST_IDLE returned from next_state_of() marks the end of the frame.
    localparam state_t FIRST_ST = (VSYNC_LINES > 0) ? ST_VSYNC :
                                  (V_BACK > 0)      ? ST_VBACK :
                                  (V_ACTIVE > 0)    ? ST_ACTIVE : ST_VFRONT;

    function automatic state_t next_state_of(input state_t s);
        case (s)
            ST_VSYNC:  return (V_BACK > 0)   ? ST_VBACK  :
                              (V_ACTIVE > 0) ? ST_ACTIVE :
                              (V_FRONT > 0)  ? ST_VFRONT : ST_IDLE;
            ST_VBACK:  return (V_ACTIVE > 0) ? ST_ACTIVE :
                              (V_FRONT > 0)  ? ST_VFRONT : ST_IDLE;
            ST_ACTIVE: return (V_FRONT > 0)  ? ST_VFRONT : ST_IDLE;
            default:   return ST_IDLE;
        endcase
    endfunction

    function automatic logic [VC_W-1:0] last_line_of(input state_t s);
        case (s)
            ST_VSYNC:  return VC_W'(VSYNC_LINES - 1);
            ST_VBACK:  return VC_W'(V_BACK - 1);
            ST_ACTIVE: return VC_W'(V_ACTIVE - 1);
            ST_VFRONT: return VC_W'(V_FRONT - 1);
            default:   return '0;
        endcase
    endfunction

    state_t          state, state_n;
    logic [HC_W-1:0] hc, hc_n;
    logic [VC_W-1:0] vc, vc_n;
    logic            frame_end;
    logic            frame_start;
    state_t          after_st;

    pat_sel_t        sel_lat;
    logic [11:0]     fcnt_lat;
    logic [2:0]      bar;
    logic [BP_W-1:0] bar_px;

    logic            line_end;
    logic            in_href;
    logic [9:0]      px_x;
    logic [9:0]      px_y;
    logic [11:0]     pix;
    logic [7:0]      byte_dat;

    assign line_end = (hc == HC_W'(LINE_LEN - 1));
    assign in_href  = (state == ST_ACTIVE) && ({1'b0, hc} < (HC_W + 1)'(2 * H_ACTIVE));
    assign px_x     = 10'(hc[HC_W-1:1]);
    assign px_y     = 10'(vc);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            hc    <= '0;
            vc    <= '0;
        end else begin
            state <= state_n;
            hc    <= hc_n;
            vc    <= vc_n;
        end
    end

    always_comb begin
        state_n     = state;
        hc_n        = hc;
        vc_n        = vc;
        frame_end   = 1'b0;
        frame_start = 1'b0;
        after_st    = next_state_of(state);
        if (state == ST_IDLE) begin
            hc_n = '0;
            vc_n = '0;
            if (enable) begin
                state_n     = FIRST_ST;
                frame_start = 1'b1;
            end
        end else if (!line_end) begin
            hc_n = hc + 1'b1;
        end else begin
            hc_n = '0;
            if (vc != last_line_of(state)) begin
                vc_n = vc + 1'b1;
            end else begin
                vc_n = '0;
                if (after_st != ST_IDLE) begin
                    state_n = after_st;
                end else begin
                    frame_end = 1'b1;
                    if (enable) begin
                        state_n     = FIRST_ST;
                        frame_start = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
        end
    end

    // Frame-start snapshot; the count includes the frame finishing now or just finished.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_lat  <= PAT_BARS;
            fcnt_lat <= '0;
        end else if (frame_start) begin
            sel_lat  <= pat_sel_t'(pattern_sel);
            fcnt_lat <= frame_cnt[11:0] + {11'b0, frame_done}
                        + {11'b0, (state != ST_IDLE)};
        end
    end

    // Bar index advances every BAR_W pixels, replacing an x/BAR_W divide.
    always_ff @(posedge clk) begin
        if (reset) begin
            bar    <= '0;
            bar_px <= '0;
        end else if (!in_href) begin
            bar    <= '0;
            bar_px <= '0;
        end else if (hc[0]) begin
            if (bar_px == BP_W'(BAR_W - 1)) begin
                bar_px <= '0;
                bar    <= bar + 3'd1;
            end else begin
                bar_px <= bar_px + 1'b1;
            end
        end
    end

    cam_dvp_pattern u_pattern (
        .x    (px_x),
        .y    (px_y),
        .bar  (bar),
        .sel  (sel_lat),
        .fcnt (fcnt_lat),
        .pix  (pix)
    );

    assign byte_dat = hc[0] ? pix[7:0] : {4'h0, pix[11:8]};

    always_ff @(posedge clk) begin
        if (reset) begin
            cam_vsynk  <= 1'b0;
            cam_href   <= 1'b0;
            cam_data   <= 8'h00;
            frame_done <= 1'b0;
            frame_cnt  <= 16'h0000;
        end else begin
            cam_vsynk  <= (state == ST_VSYNC);
            cam_href   <= in_href;
            cam_data   <= in_href ? byte_dat : 8'h00;
            frame_done <= frame_end;
            if (frame_done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cam_dvp_source.sv
// Directed bench for cam_dvp_source with a shrunk frame: 20-cycle lines, 140-cycle frames.
module tb_cam_dvp_source;
    import cam_dvp_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        cam_vsynk;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        frame_done;
    logic [15:0] frame_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_bars [16] = '{8'h0F, 8'hFF, 8'h0F, 8'hF0, 8'h00, 8'hFF, 8'h00, 8'hF0,
                                  8'h0F, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00};

    cam_dvp_source #(
        .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(4),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .cam_vsynk   (cam_vsynk),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // which: 0 vsync, 1 href, 2 frame_done
    task automatic wait_for(input int which, input int budget, input string what, output int n);
        logic s;
        n = 0;
        s = 1'b0;
        forever begin
            case (which)
                0:       s = cam_vsynk;
                1:       s = cam_href;
                default: s = frame_done;
            endcase
            if (s === 1'b1 || n >= budget) break;
            tick();
            n++;
        end
        vectors++;
        if (s !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: timeout after %0d cycles, required within %0d", what, n, budget);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors += 5;
        if (cam_vsynk !== 1'b0)   begin miscompares++; $display("FAIL reset_vsync: got %b want 0", cam_vsynk); end
        if (cam_href !== 1'b0)    begin miscompares++; $display("FAIL reset_href: got %b want 0", cam_href); end
        if (cam_data !== 8'h00)   begin miscompares++; $display("FAIL reset_data: got %h want 00", cam_data); end
        if (frame_done !== 1'b0)  begin miscompares++; $display("FAIL reset_done: got %b want 0", frame_done); end
        if (frame_cnt !== 16'h0)  begin miscompares++; $display("FAIL reset_cnt: got %h want 0000", frame_cnt); end
    endtask

    task automatic test_bars();
        int n;
        apply_reset();
        pattern_sel = 2'd0;
        enable = 1'b1;
        wait_for(0, 20, "bars_vsync_rise", n);
        n = 0;
        while (cam_vsynk === 1'b1 && n < 100) begin tick(); n++; end
        vectors++;
        if (n != 20) begin miscompares++; $display("FAIL bars_vsync_len: got %0d want 20", n); end
        wait_for(1, 40, "bars_href_rise", n);
        vectors++;
        if (n != 20) begin miscompares++; $display("FAIL bars_vback_len: got %0d want 20", n); end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (cam_href !== 1'b1 || cam_data !== exp_bars[i] || cam_vsynk !== 1'b0) begin
                miscompares++;
                $display("FAIL bars_byte%0d: got href=%b data=%h want href=1 data=%h", i, cam_href, cam_data, exp_bars[i]);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (cam_href !== 1'b0 || cam_data !== 8'h00) begin
                miscompares++;
                $display("FAIL bars_blank%0d: got href=%b data=%h want 0/00", i, cam_href, cam_data);
            end
            tick();
        end
    endtask

    task automatic test_free_run();
        int n;
        wait_for(2, 200, "free_done1", n);
        vectors++;
        if (frame_cnt !== 16'd0) begin miscompares++; $display("FAIL free_cnt_at_done: got %0d want 0", frame_cnt); end
        tick();
        vectors += 3;
        if (frame_cnt !== 16'd1) begin miscompares++; $display("FAIL free_cnt1: got %0d want 1", frame_cnt); end
        if (cam_vsynk !== 1'b1)  begin miscompares++; $display("FAIL free_vsync_after_done1: got %b want 1", cam_vsynk); end
        if (frame_done !== 1'b0) begin miscompares++; $display("FAIL free_done_width: got %b want 0", frame_done); end
        wait_for(2, 300, "free_done2", n);
        vectors++;
        if (n != 139) begin miscompares++; $display("FAIL free_period: got %0d want 140", n + 1); end
        tick();
        vectors += 2;
        if (frame_cnt !== 16'd2) begin miscompares++; $display("FAIL free_cnt2: got %0d want 2", frame_cnt); end
        if (cam_vsynk !== 1'b1)  begin miscompares++; $display("FAIL free_vsync_after_done2: got %b want 1", cam_vsynk); end
    endtask

    // Entered on frame cycle 1; frame cycle 70 sits mid active line y=1.
    task automatic test_reset_mid();
        for (int i = 0; i < 69; i++) tick();
        vectors++;
        if (cam_href !== 1'b1) begin miscompares++; $display("FAIL rmid_pre_href: got %b want 1", cam_href); end
        reset = 1'b1;
        tick();
        vectors += 4;
        if (cam_href !== 1'b0)   begin miscompares++; $display("FAIL rmid_href: got %b want 0", cam_href); end
        if (cam_data !== 8'h00)  begin miscompares++; $display("FAIL rmid_data: got %h want 00", cam_data); end
        if (cam_vsynk !== 1'b0)  begin miscompares++; $display("FAIL rmid_vsync: got %b want 0", cam_vsynk); end
        if (frame_cnt !== 16'h0) begin miscompares++; $display("FAIL rmid_cnt: got %0d want 0", frame_cnt); end
        reset = 1'b0;
    endtask

    task automatic test_ramp();
        int n;
        int offs [6] = '{0, 14, 15, 50, 51, 74};
        logic [7:0] expv [6] = '{8'h00, 8'h07, 8'h00, 8'h05, 8'h02, 8'h07};
        int k;
        apply_reset();
        pattern_sel = 2'd1;
        enable = 1'b1;
        wait_for(1, 60, "ramp_href_rise", n);
        k = 0;
        for (int c = 0; c <= 75; c++) begin
            if (k < 6 && c == offs[k]) begin
                vectors++;
                if (cam_data !== expv[k]) begin
                    miscompares++;
                    $display("FAIL ramp_off%0d: got %h want %h", c, cam_data, expv[k]);
                end
                k++;
            end
            if (c == 75) begin
                vectors++;
                if (cam_data !== 8'h03) begin miscompares++; $display("FAIL ramp_off75: got %h want 03", cam_data); end
            end
            tick();
        end
    endtask

    task automatic test_checker();
        int n;
        int hrefs;
        int nonzero;
        apply_reset();
        pattern_sel = 2'd3;
        enable = 1'b1;
        wait_for(1, 60, "check_href_rise", n);
        hrefs = 0;
        nonzero = 0;
        for (int c = 0; c < 80; c++) begin
            if (cam_href === 1'b1) hrefs++;
            if (cam_data !== 8'h00) nonzero++;
            tick();
        end
        vectors += 2;
        if (hrefs != 64)  begin miscompares++; $display("FAIL check_href_count: got %0d want 64", hrefs); end
        if (nonzero != 0) begin miscompares++; $display("FAIL check_nonzero: got %0d want 0", nonzero); end
    endtask

    task automatic test_flat();
        int n;
        apply_reset();
        pattern_sel = 2'd0;
        enable = 1'b1;
        wait_for(2, 200, "flat_done1", n);
        tick();
        wait_for(2, 200, "flat_done2", n);
        tick();
        pattern_sel = 2'd2;
        wait_for(1, 60, "flat_href3", n);
        vectors++;
        if (cam_data !== 8'h0F) begin miscompares++; $display("FAIL flat_sel_ignored: got %h want 0F", cam_data); end
        wait_for(2, 200, "flat_done3", n);
        tick();
        wait_for(1, 60, "flat_href4", n);
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (cam_data !== ((i % 2) ? 8'h03 : 8'h00)) begin
                miscompares++;
                $display("FAIL flat_byte%0d: got %h want %h", i, cam_data, (i % 2) ? 8'h03 : 8'h00);
            end
            tick();
        end
    endtask

    task automatic test_drop_enable();
        int n;
        int bad;
        apply_reset();
        pattern_sel = 2'd0;
        enable = 1'b1;
        wait_for(0, 20, "drop_vsync_rise", n);
        for (int i = 0; i < 49; i++) tick();
        enable = 1'b0;
        wait_for(2, 200, "drop_done", n);
        vectors++;
        if (n != 90) begin miscompares++; $display("FAIL drop_done_cycle: got %0d want 140", n + 50); end
        tick();
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (cam_vsynk !== 1'b0 || cam_href !== 1'b0 || cam_data !== 8'h00 || frame_done !== 1'b0) bad++;
            tick();
        end
        vectors += 2;
        if (bad != 0) begin miscompares++; $display("FAIL drop_idle_outputs: got %0d active cycles want 0", bad); end
        if (frame_cnt !== 16'd1) begin miscompares++; $display("FAIL drop_cnt: got %0d want 1", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_bars();
        test_free_run();
        test_reset_mid();
        test_ramp();
        test_checker();
        test_flat();
        test_drop_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
